// File: rtl/trigger_conditioner.sv
// Trigger conditioner: synchronises an external trigger, merges it with a software
// trigger, and issues trig_o aligned to a prescaled clock-enable with optional holdoff.
module trigger_conditioner #(
  parameter int PRESCALE_WIDTH = 16,
  parameter int HOLDOFF_WIDTH  = 18,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      ext_trig_i,
  input  logic                      sw_trig_i,
  input  logic                      enable_i,
  input  logic                      edge_sel_i,
  input  logic                      single_i,
  input  logic                      arm_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  input  logic [HOLDOFF_WIDTH-1:0]  holdoff_i,
  output logic                      ce_o,
  output logic                      trig_o,
  output logic                      armed_o,
  output logic                      missed_o,
  output logic [COUNT_WIDTH-1:0]    trig_count_o
);

  typedef enum logic [1:0] {DISARMED, ARMED, PENDING, HOLDOFF} state_e;

  state_e                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] pc_q, pc_d;
  logic                      ce_q, ce_d;
  logic [2:0]                sync_q, sync_d;
  logic [HOLDOFF_WIDTH-1:0]  ho_q, ho_d;
  logic [COUNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                      missed_q, missed_d;

  logic   ext_evt;
  logic   evt;
  logic   trig;
  state_e exit_state;

  always_comb begin
    // sync_q[1] is the synchronised level, sync_q[2] its one-cycle history
    ext_evt    = edge_sel_i ? (~sync_q[1] & sync_q[2]) : (sync_q[1] & ~sync_q[2]);
    evt        = ext_evt | sw_trig_i;
    trig       = (state_q == PENDING) & ce_q & enable_i;
    exit_state = single_i ? DISARMED : ARMED;

    sync_d = {sync_q[1:0], ext_trig_i};

    if (pc_q == '0) begin
      pc_d = prescale_i;
      ce_d = 1'b1;
    end else begin
      pc_d = pc_q - PRESCALE_WIDTH'(1);
      ce_d = 1'b0;
    end

    state_d  = state_q;
    ho_d     = ho_q;
    missed_d = enable_i & evt & ((state_q == PENDING) | (state_q == HOLDOFF));
    cnt_d    = trig ? cnt_q + COUNT_WIDTH'(1) : cnt_q;

    if (!enable_i) begin
      state_d = DISARMED;
      ho_d    = '0;
    end else begin
      unique case (state_q)
        DISARMED: if (!single_i || arm_i) state_d = ARMED;
        ARMED:    if (evt) state_d = PENDING;
        PENDING: begin
          if (trig) begin
            if (holdoff_i == '0) begin
              state_d = exit_state;
            end else begin
              state_d = HOLDOFF;
              ho_d    = holdoff_i - HOLDOFF_WIDTH'(1);
            end
          end
        end
        HOLDOFF: begin
          if (ce_q) begin
            if (ho_q == '0) state_d = exit_state;
            else            ho_d    = ho_q - HOLDOFF_WIDTH'(1);
          end
        end
        default: state_d = DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= DISARMED;
      pc_q     <= '0;
      ce_q     <= 1'b0;
      sync_q   <= '0;
      ho_q     <= '0;
      cnt_q    <= '0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ce_q     <= ce_d;
      sync_q   <= sync_d;
      ho_q     <= ho_d;
      cnt_q    <= cnt_d;
      missed_q <= missed_d;
    end
  end

  assign ce_o         = ce_q;
  assign trig_o       = trig;
  assign armed_o      = (state_q == ARMED);
  assign missed_o     = missed_q;
  assign trig_count_o = cnt_q;

endmodule

// File: tb/tb_trigger_conditioner.sv
// Scoreboard bench for trigger_conditioner: a behavioural model predicts every
// post-edge output vector, the monitor compares them one cycle at a time.
module tb_trigger_conditioner;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ext_trig_i = 1'b0;
  logic        sw_trig_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        edge_sel_i = 1'b0;
  logic        single_i = 1'b0;
  logic        arm_i = 1'b0;
  logic [15:0] prescale_i = '0;
  logic [17:0] holdoff_i = '0;
  logic        ce_o, trig_o, armed_o, missed_o;
  logic [3:0]  trig_count_o;

  trigger_conditioner #(
    .PRESCALE_WIDTH(16),
    .HOLDOFF_WIDTH (18),
    .COUNT_WIDTH   (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ext_trig_i  (ext_trig_i),
    .sw_trig_i   (sw_trig_i),
    .enable_i    (enable_i),
    .edge_sel_i  (edge_sel_i),
    .single_i    (single_i),
    .arm_i       (arm_i),
    .prescale_i  (prescale_i),
    .holdoff_i   (holdoff_i),
    .ce_o        (ce_o),
    .trig_o      (trig_o),
    .armed_o     (armed_o),
    .missed_o    (missed_o),
    .trig_count_o(trig_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int trig_seen = 0;
  int missed_seen = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // Reference model state
  localparam int S_DIS = 0, S_ARM = 1, S_PEND = 2, S_HOLD = 3;
  int       m_st, m_pc, m_ho;
  bit       m_ce, m_missed;
  bit [3:0] m_cnt;
  bit [2:0] m_sy;

  task automatic model_reset();
    m_st = S_DIS; m_pc = 0; m_ho = 0; m_ce = 0; m_missed = 0; m_cnt = 0; m_sy = 0;
  endtask

  task automatic model_step();
    bit ev, fire, ntrig;
    int nst, leave;
    ev    = sw_trig_i | (edge_sel_i ? (m_sy[2] && !m_sy[1]) : (m_sy[1] && !m_sy[2]));
    fire  = (m_st == S_PEND) && m_ce && enable_i;
    leave = single_i ? S_DIS : S_ARM;
    nst   = m_st;
    if (!enable_i) begin
      nst  = S_DIS;
      m_ho = 0;
    end else begin
      case (m_st)
        S_DIS:  if (!single_i || arm_i) nst = S_ARM;
        S_ARM:  if (ev) nst = S_PEND;
        S_PEND: if (fire) begin
          if (holdoff_i == 0) nst = leave;
          else begin nst = S_HOLD; m_ho = int'(holdoff_i) - 1; end
        end
        default: if (m_ce) begin
          if (m_ho == 0) nst = leave;
          else m_ho = m_ho - 1;
        end
      endcase
    end
    m_missed = enable_i && ev && (m_st == S_PEND || m_st == S_HOLD);
    if (fire) m_cnt = m_cnt + 4'd1;
    if (m_pc == 0) begin m_pc = int'(prescale_i); m_ce = 1; end
    else begin m_pc = m_pc - 1; m_ce = 0; end
    m_sy = {m_sy[1:0], ext_trig_i};
    m_st = nst;
    ntrig = (m_st == S_PEND) && m_ce && enable_i;
    exp_q.push_back({m_ce, ntrig, m_st == S_ARM, m_missed, m_cnt});
  endtask

  always @(posedge clk_i) begin
    logic [7:0] e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("cycle", {24'd0, ce_o, trig_o, armed_o, missed_o, trig_count_o}, {24'd0, e});
    end
    if (trig_o) trig_seen++;
    if (missed_o) missed_seen++;
  end

  task automatic tick();
    model_step();
    @(negedge clk_i);
    sw_trig_i = 1'b0;
    arm_i     = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input logic ext_level);
    ext_trig_i = ext_level;
    rst_ni = 1'b0;
    #1;
    check_eq("reset_outs", {24'd0, ce_o, trig_o, armed_o, missed_o, trig_count_o}, 32'd0);
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    int t0, m0;
    model_reset();
    @(negedge clk_i);

    // Continuous mode, prescale 3, single software trigger
    prescale_i = 16'd3; enable_i = 1'b1; single_i = 1'b0; holdoff_i = '0;
    do_reset(1'b0);
    ticks(10);
    t0 = trig_seen;
    sw_trig_i = 1'b1; tick();
    ticks(8);
    check_eq("sw_one_trig", trig_seen - t0, 1);
    check_eq("sw_count", {28'd0, trig_count_o}, 32'd1);

    // External edges; ext high across reset release counts as a rising edge
    do_reset(1'b1);
    ticks(10);
    ext_trig_i = 1'b0; ticks(6);
    ext_trig_i = 1'b1; ticks(8);
    ext_trig_i = 1'b0; ticks(8);
    edge_sel_i = 1'b1; ticks(4);
    ext_trig_i = 1'b1; ticks(4);
    check_eq("fall_sel_ignores_rise", {31'd0, armed_o}, 32'd1);
    ext_trig_i = 1'b0; ticks(8);
    edge_sel_i = 1'b0; ticks(2);

    // Holdoff of two ce pulses with a trigger arriving during holdoff
    prescale_i = 16'd0; holdoff_i = 18'd2;
    ticks(4);
    t0 = trig_seen; m0 = missed_seen;
    sw_trig_i = 1'b1; tick();
    tick();
    sw_trig_i = 1'b1; tick();
    ticks(6);
    check_eq("holdoff_missed", missed_seen - m0, 1);
    check_eq("holdoff_trigs", trig_seen - t0, 1);
    check_eq("holdoff_rearm", {31'd0, armed_o}, 32'd1);

    // Single-shot mode
    single_i = 1'b1; holdoff_i = '0;
    enable_i = 1'b0; tick();
    enable_i = 1'b1; ticks(3);
    check_eq("single_waits_arm", {31'd0, armed_o}, 32'd0);
    t0 = trig_seen;
    arm_i = 1'b1; tick();
    ticks(2);
    sw_trig_i = 1'b1; tick();
    ticks(3);
    sw_trig_i = 1'b1; tick();
    ticks(3);
    check_eq("single_one_trig", trig_seen - t0, 1);
    check_eq("single_disarmed", {31'd0, armed_o}, 32'd0);
    arm_i = 1'b1; tick();
    ticks(2);
    sw_trig_i = 1'b1; tick();
    ticks(3);
    check_eq("single_rearm_trig", trig_seen - t0, 2);

    // Disable while pending, then reset while in holdoff
    single_i = 1'b0; prescale_i = 16'd7;
    ticks(20);
    t0 = trig_seen;
    sw_trig_i = 1'b1; tick();
    enable_i = 1'b0; tick();
    check_eq("disable_disarms", {31'd0, armed_o}, 32'd0);
    ticks(10);
    check_eq("disable_no_trig", trig_seen - t0, 0);
    enable_i = 1'b1; prescale_i = 16'd0; holdoff_i = 18'd5;
    ticks(12);
    sw_trig_i = 1'b1; tick();
    ticks(2);
    do_reset(1'b0);
    ticks(10);

    // Counter wrap with a 4-bit count
    prescale_i = 16'd0; holdoff_i = '0; single_i = 1'b0; enable_i = 1'b1;
    do_reset(1'b0);
    ticks(3);
    for (int k = 0; k < 17; k++) begin
      sw_trig_i = 1'b1; tick();
      ticks(2);
    end
    ticks(2);
    check_eq("count_wrap", {28'd0, trig_count_o}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trigger_conditioner.md
TRIGGER_CONDITIONER -- requirements
Module: trigger_conditioner

Interface
REQ-001 Parameter PRESCALE_WIDTH, default 16: width of the clock-enable prescaler.
REQ-002 Parameter HOLDOFF_WIDTH, default 18: width of the holdoff counter.
REQ-003 Parameter COUNT_WIDTH, default 16: width of the issued-trigger counter.
REQ-004 clk_i  in  1  system clock; all logic on its rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 ext_trig_i  in  1  external trigger, asynchronous to clk_i.
REQ-007 sw_trig_i  in  1  software trigger, one-cycle pulse, synchronous.
REQ-008 enable_i  in  1  block enable level.
REQ-009 edge_sel_i  in  1  ext_trig_i edge: 0 rising, 1 falling.
REQ-010 single_i  in  1  0 continuous re-arm, 1 single-shot.
REQ-011 arm_i  in  1  one-cycle arm request, used in single-shot mode.
REQ-012 prescale_i  in  PRESCALE_WIDTH  ce_o period minus one.
REQ-013 holdoff_i  in  HOLDOFF_WIDTH  ce_o pulses ignored after each trig_o.
REQ-014 ce_o  out  1  clock-enable pulse for the downstream toggle stage.
REQ-015 trig_o  out  1  trigger pulse, asserted only in a cycle where ce_o is high.
REQ-016 armed_o  out  1  high in ARMED state.
REQ-017 missed_o  out  1  one-cycle pulse: event ignored (PENDING or HOLDOFF).
REQ-018 trig_count_o  out  COUNT_WIDTH  number of trig_o pulses issued, wrapping.

Function
REQ-019 Prescaler: downcounter pc; pc==0 -> reload prescale_i and register ce_o=1 next cycle; else pc-1 and ce_o=0; period prescale_i+1 clocks; prescale_i=0 -> ce_o constantly high; prescale_i change takes effect at next reload; runs regardless of enable_i.
REQ-020 ext_trig_i passes a 2-flop synchronizer plus one history flop; event = selected edge between flops 2 and 3; ext edge to event latency 3 clocks.
REQ-021 Event = ext edge OR sw_trig_i; simultaneous sources count as one event.
REQ-022 States: DISARMED, ARMED, PENDING, HOLDOFF.
REQ-023 Any state with enable_i=0 -> DISARMED next cycle; pending event and holdoff count discarded; no trig_o issued in that cycle or after.
REQ-024 DISARMED -> ARMED when enable_i=1 and (single_i=0 or arm_i=1).
REQ-025 ARMED -> PENDING on event; events in DISARMED dropped silently.
REQ-026 PENDING: trig_o = (state==PENDING) & ce_o; first ce_o at or after the cycle after the event; worst case prescale_i+1 clocks wait.
REQ-027 On trig_o: holdoff_i==0 -> ARMED (single_i=0) or DISARMED (single_i=1); else HOLDOFF, counter loaded holdoff_i-1.
REQ-028 HOLDOFF: on each ce_o, counter==0 -> exit per REQ-027 single_i rule, else decrement; exactly holdoff_i ce_o pulses spent in HOLDOFF.
REQ-029 Events in PENDING or HOLDOFF: not queued, missed_o pulsed next cycle.
REQ-030 arm_i ignored outside DISARMED; single_i sampled at exit from PENDING/HOLDOFF.
REQ-031 trig_count_o increments on each trig_o, wraps from all-ones to 0.

Reset
REQ-032 Reset: pc=0, ce_o=0, state DISARMED, sync flops 0, holdoff counter 0, trig_count_o=0, missed_o=0; trig_o and armed_o low.
REQ-033 ext_trig_i high at reset release registers one rising edge 3 clocks later; dropped unless ARMED.
REQ-034 Reset mid-operation aborts PENDING/HOLDOFF immediately; no trig_o until re-armed.

Verification
REQ-035 prescale_i=3, enable_i=1, single_i=0: ce_o every 4 clocks; sw_trig_i -> exactly one trig_o aligned to next ce_o; trig_count_o=1.
REQ-036 ext_trig_i rising edge, edge_sel_i=0: PENDING 3 clocks later; edge_sel_i=1 same stimulus: no event until falling edge.
REQ-037 holdoff_i=2, prescale_i=0: trig_o, then two ce_o in HOLDOFF; sw_trig_i in holdoff -> missed_o pulse, no trig_o; ARMED after.
REQ-038 single_i=1: arm_i, two triggers -> one trig_o, DISARMED; second arm_i -> next trigger fires.
REQ-039 enable_i dropped while PENDING with prescale_i=7 -> no trig_o, DISARMED next cycle; rst_ni pulse in HOLDOFF -> all outputs reset values.
REQ-040 COUNT_WIDTH=4, 17 triggers -> trig_count_o=1 (wrap).
